// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared types and constants for the bit-serial adder controller
package serial_adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/full_adder.sv
// rtl/full_adder.sv - single-bit full adder cell used as the serial datapath
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - LSB-first bit-serial add controller around one full_adder
// Optional subtract mode (sub port) enabled by defining SERIAL_ADDER_SUB_EN.
module serial_adder_ctrl
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
   input  logic             sub,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             busy
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   state_e           state;
   state_e           state_nx;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] sum_sh;
   logic [WIDTH-1:0] sum_sh_nx;
   logic [CNT_W-1:0] cnt;
   logic             carry;
   logic             carry_init;
   logic             accept;
   logic             last_bit;
   logic             fa_b;
   logic             fa_s;
   logic             fa_co;

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign accept    = in_valid && in_ready;
   assign last_bit  = (state == RUN) && (cnt == CNT_W'(WIDTH - 1));

`ifdef SERIAL_ADDER_SUB_EN
   logic sub_q;

   // B is stored raw and inverted per bit, so the held sub flag drives the datapath.
   assign fa_b       = b_sh[0] ^ sub_q;
   assign carry_init = sub ? 1'b1 : cin;
`else
   assign fa_b       = b_sh[0];
   assign carry_init = cin;
`endif

   full_adder u_fa (
      .a    (a_sh[0]),
      .b    (fa_b),
      .cin  (carry),
      .sum  (fa_s),
      .cout (fa_co)
   );

   generate
      if (WIDTH == 1) begin : g_w1
         assign sum_sh_nx = fa_s;
      end else begin : g_wn
         assign sum_sh_nx = {fa_s, sum_sh[WIDTH-1:1]};
      end
   endgenerate

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (in_valid) state_nx = RUN;
         RUN:     if (last_bit) state_nx = DONE;
         DONE:    if (out_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         a_sh   <= '0;
         b_sh   <= '0;
         sum_sh <= '0;
         cnt    <= '0;
         carry  <= 1'b0;
         sum    <= '0;
         cout   <= 1'b0;
         busy   <= 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
         sub_q  <= 1'b0;
`endif
      end else begin
         state <= state_nx;
         busy  <= (state_nx != IDLE);
         if (accept) begin
            a_sh   <= a;
            b_sh   <= b;
            carry  <= carry_init;
            cnt    <= '0;
            sum_sh <= '0;
`ifdef SERIAL_ADDER_SUB_EN
            sub_q  <= sub;
`endif
         end else if (state == RUN) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            carry  <= fa_co;
            sum_sh <= sum_sh_nx;
            cnt    <= cnt + CNT_W'(1);
            // Result registers only change on the final bit, keeping DONE outputs stable.
            if (last_bit) begin
               sum  <= sum_sh_nx;
               cout <= fa_co;
            end
         end
      end
   end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb/tb_serial_adder_ctrl.sv - directed self-checking bench for serial_adder_ctrl (WIDTH 8 and 1)
module tb_serial_adder_ctrl;
   import serial_adder_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;

   logic       in_valid8 = 1'b0;
   logic       in_ready8;
   logic [7:0] a8 = '0;
   logic [7:0] b8 = '0;
   logic       cin8 = 1'b0;
   logic       out_valid8;
   logic       out_ready8 = 1'b0;
   logic [7:0] sum8;
   logic       cout8;
   logic       busy8;

   logic       in_valid1 = 1'b0;
   logic       in_ready1;
   logic [0:0] a1 = '0;
   logic [0:0] b1 = '0;
   logic       cin1 = 1'b0;
   logic       out_valid1;
   logic       out_ready1 = 1'b0;
   logic [0:0] sum1;
   logic       cout1;
   logic       busy1;

`ifdef SERIAL_ADDER_SUB_EN
   logic       sub8 = 1'b0;
   logic       sub1 = 1'b0;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   serial_adder_ctrl #(.WIDTH(8)) dut8 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid8),
      .in_ready  (in_ready8),
      .a         (a8),
      .b         (b8),
      .cin       (cin8),
`ifdef SERIAL_ADDER_SUB_EN
      .sub       (sub8),
`endif
      .out_valid (out_valid8),
      .out_ready (out_ready8),
      .sum       (sum8),
      .cout      (cout8),
      .busy      (busy8)
   );

   serial_adder_ctrl #(.WIDTH(1)) dut1 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid1),
      .in_ready  (in_ready1),
      .a         (a1),
      .b         (b1),
      .cin       (cin1),
`ifdef SERIAL_ADDER_SUB_EN
      .sub       (sub1),
`endif
      .out_valid (out_valid1),
      .out_ready (out_ready1),
      .sum       (sum1),
      .cout      (cout1),
      .busy      (busy1)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Accepts one 8-bit op, checks latency/in_ready during RUN and the result; leaves DUT in DONE.
   task automatic start_op8(input logic [7:0] a, input logic [7:0] b, input logic c,
                            input logic [7:0] exp_sum, input logic exp_cout, input string name);
      int lat;
      checks++;
      if (in_ready8 !== 1'b1) begin
         errors++;
         $display("FAIL %s in_ready_before_accept got %b want 1", name, in_ready8);
      end
      a8 = a; b8 = b; cin8 = c; in_valid8 = 1'b1;
      tick();
      in_valid8 = 1'b0;
      a8 = ~a; b8 = ~b; cin8 = ~c;
      lat = 0;
      while (out_valid8 !== 1'b1 && lat < 20) begin
         checks++;
         if (in_ready8 !== 1'b0 || busy8 !== 1'b1) begin
            errors++;
            $display("FAIL %s run_flags got in_ready=%b busy=%b want 0 1", name, in_ready8, busy8);
         end
         tick();
         lat++;
      end
      checks++;
      if (lat != 8) begin
         errors++;
         $display("FAIL %s latency got %0d want 8", name, lat);
      end
      checks++;
      if (sum8 !== exp_sum || cout8 !== exp_cout) begin
         errors++;
         $display("FAIL %s result got sum=%h cout=%b want sum=%h cout=%b",
                  name, sum8, cout8, exp_sum, exp_cout);
      end
   endtask

   task automatic release8(input string name);
      out_ready8 = 1'b1;
      tick();
      out_ready8 = 1'b0;
      checks++;
      if (out_valid8 !== 1'b0 || in_ready8 !== 1'b1 || busy8 !== 1'b0) begin
         errors++;
         $display("FAIL %s release got out_valid=%b in_ready=%b busy=%b want 0 1 0",
                  name, out_valid8, in_ready8, busy8);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      checks++;
      if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0 || sum8 !== 8'h00 ||
          cout8 !== 1'b0 || busy8 !== 1'b0) begin
         errors++;
         $display("FAIL reset8 got in_ready=%b out_valid=%b sum=%h cout=%b busy=%b want 1 0 00 0 0",
                  in_ready8, out_valid8, sum8, cout8, busy8);
      end
      checks++;
      if (in_ready1 !== 1'b1 || out_valid1 !== 1'b0 || sum1 !== 1'b0 ||
          cout1 !== 1'b0 || busy1 !== 1'b0) begin
         errors++;
         $display("FAIL reset1 got in_ready=%b out_valid=%b sum=%b cout=%b busy=%b want 1 0 0 0 0",
                  in_ready1, out_valid1, sum1, cout1, busy1);
      end
   endtask

   task automatic test_add_basic();
      start_op8(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, "add_5a_3c");
      release8("add_5a_3c");
      start_op8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "add_ff_01");
      release8("add_ff_01");
      start_op8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, "add_ff_ff_c");
      release8("add_ff_ff_c");
   endtask

   task automatic test_backpressure();
      start_op8(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, "bp_first");
      for (int i = 0; i < 5; i++) begin
         a8 = 8'hC3; b8 = 8'h11; cin8 = 1'b1; in_valid8 = 1'b1;
         tick();
         checks++;
         if (out_valid8 !== 1'b1 || in_ready8 !== 1'b0 || sum8 !== 8'h46 || cout8 !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold%0d got out_valid=%b in_ready=%b sum=%h cout=%b want 1 0 46 0",
                     i, out_valid8, in_ready8, sum8, cout8);
         end
      end
      in_valid8 = 1'b0;
      release8("bp_first");
      start_op8(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, "bp_next");
      release8("bp_next");
   endtask

   task automatic test_reset_mid_run();
      a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b0; in_valid8 = 1'b1;
      tick();
      in_valid8 = 1'b0;
      tick();
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0 || sum8 !== 8'h00 || busy8 !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid_run got in_ready=%b out_valid=%b sum=%h busy=%b want 1 0 00 0",
                  in_ready8, out_valid8, sum8, busy8);
      end
      start_op8(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, "after_rst");
      release8("after_rst");
   endtask

   task automatic test_width1();
      logic [7:0] exp_s;
      logic [7:0] exp_c;
      exp_s = 8'b1001_0110;
      exp_c = 8'b1110_1000;
      for (int i = 0; i < 8; i++) begin
         int lat;
         a1 = 1'(i >> 2); b1 = 1'(i >> 1); cin1 = 1'(i); in_valid1 = 1'b1;
         tick();
         in_valid1 = 1'b0;
         lat = 0;
         while (out_valid1 !== 1'b1 && lat < 10) begin
            tick();
            lat++;
         end
         checks++;
         if (lat != 1 || sum1 !== exp_s[i] || cout1 !== exp_c[i]) begin
            errors++;
            $display("FAIL w1_case%0d got lat=%0d sum=%b cout=%b want lat=1 sum=%b cout=%b",
                     i, lat, sum1, cout1, exp_s[i], exp_c[i]);
         end
         out_ready1 = 1'b1;
         tick();
         out_ready1 = 1'b0;
      end
   endtask

`ifdef SERIAL_ADDER_SUB_EN
   task automatic test_subtract();
      sub8 = 1'b1;
      start_op8(8'h10, 8'h01, 1'b0, 8'h0F, 1'b1, "sub_10_01");
      sub8 = 1'b0;
      release8("sub_10_01");
      sub8 = 1'b1;
      start_op8(8'h01, 8'h02, 1'b0, 8'hFF, 1'b0, "sub_01_02");
      sub8 = 1'b0;
      release8("sub_01_02");
   endtask
`endif

   initial begin
      test_reset();
      test_add_basic();
      test_backpressure();
      test_reset_mid_run();
      test_width1();
`ifdef SERIAL_ADDER_SUB_EN
      test_subtract();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
